trigger_unit: RTL and testbench

- Parametrised trigger qualifier for the capture path.
- Synchronises NUM_CH asynchronous trigger inputs and selects one channel at run time.
- Detects the programmed condition: rising edge, falling edge, either edge, or high level.
- Enforces a post-arm holdoff, then holds a sticky trigger until the capture engine reports done. Sits between the external pins and the capture controller.

---
 rtl/trigger_pkg.sv | 37 +++
 rtl/sync_edge_detect.sv | 39 +++
 rtl/trigger_unit.sv | 151 +++++++++++++++
 tb/tb_trigger_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// trigger_pkg: shared types and helpers for the trigger qualifier.
//   trig_mode_t  - detection condition selected by the trig_mode input
//   trig_state_t - qualifier FSM states
//   modeEvent()  - maps a channel's level/rise/fall onto the chosen condition
package trigger_pkg;

  typedef enum logic [1:0] {
    TRIG_FALL  = 2'b00,
    TRIG_RISE  = 2'b01,
    TRIG_BOTH  = 2'b10,
    TRIG_LEVEL = 2'b11
  } trig_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_HOLDOFF   = 2'b01,
    ST_WAIT      = 2'b10,
    ST_TRIGGERED = 2'b11
  } trig_state_t;

  localparam int TRIG_COUNT_W = 16;
  localparam logic [TRIG_COUNT_W-1:0] TRIG_COUNT_MAX = '1;

  function automatic logic modeEvent(input trig_mode_t mode, input logic level,
                                     input logic rise, input logic fall);
    logic result;
    case (mode)
      TRIG_FALL:  result = fall;
      TRIG_RISE:  result = rise;
      TRIG_BOTH:  result = rise | fall;
      TRIG_LEVEL: result = level;
      default:    result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser for one asynchronous pin followed
// by a delay flop, giving the synchronised level and single-cycle rise/fall.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_async    - raw asynchronous input pin
//   o_level    - synchronised level
//   o_rise     - high for one cycle after a synchronised 0->1
//   o_fall     - high for one cycle after a synchronised 1->0
module sync_edge_detect #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchroniser chain; the prev flop keeps the
  // last synchronised value so edges are seen regardless of channel selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/trigger_unit.sv
// trigger_unit: trigger qualifier between the external trigger pins and the
// capture controller. Synchronises NUM_CH pins, picks one at run time, detects
// the programmed condition, applies a post-arm holdoff and then raises a
// sticky trigger until the capture engine reports completion.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   i_trig_in            - asynchronous trigger pins
//   i_trig_src           - selected channel (values >= NUM_CH select nothing)
//   i_trig_mode          - 00 fall, 01 rise, 10 either edge, 11 high level
//   i_trig_en            - enable; dropping it aborts HOLDOFF/WAIT
//   i_armed              - enough pre-trigger samples captured
//   i_holdoff            - cycles to ignore events after arming
//   i_set_capture_done   - capture complete, clears the trigger
//   o_trigger            - sticky trigger
//   o_busy               - FSM not idle
//   o_trig_count         - saturating trigger count
// Build option: define TRIGGER_UNIT_TRIG_COUNT_EN to include the trigger
// counter; otherwise o_trig_count is tied to zero.
module trigger_unit
  import trigger_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int HOLDOFF_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         i_trig_in,
  input  logic [$clog2(NUM_CH)-1:0] i_trig_src,
  input  logic [1:0]                i_trig_mode,
  input  logic                      i_trig_en,
  input  logic                      i_armed,
  input  logic [HOLDOFF_W-1:0]      i_holdoff,
  input  logic                      i_set_capture_done,
  output logic                      o_trigger,
  output logic                      o_busy,
  output logic [TRIG_COUNT_W-1:0]   o_trig_count
);

  logic [NUM_CH-1:0]    w_level;
  logic [NUM_CH-1:0]    w_rise;
  logic [NUM_CH-1:0]    w_fall;
  logic                 w_event;
  logic                 w_fire;
  trig_state_t          r_state;
  logic [HOLDOFF_W-1:0] r_cnt;
  logic                 r_trigger;
  logic                 r_busy;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (i_trig_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  // Select the event from the chosen channel; an out-of-range index matches
  // no channel and so yields no event.
  always_comb begin
    w_event = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(i_trig_src) == c) begin
        w_event = modeEvent(trig_mode_t'(i_trig_mode), w_level[c], w_rise[c], w_fall[c]);
      end
    end
  end

  // A trigger is accepted only in WAIT, still enabled, armed, and without a
  // simultaneous capture-done (which wins and drops the event).
  assign w_fire = (r_state == ST_WAIT) && i_trig_en && !i_set_capture_done
                  && w_event && i_armed;

  // Qualifier FSM with registered trigger/busy outputs that always track the
  // next state, so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_trig_en) begin
            r_state <= ST_HOLDOFF;
            r_cnt   <= i_holdoff;
            r_busy  <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (!i_trig_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (!i_trig_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_fire) begin
            r_state   <= ST_TRIGGERED;
            r_trigger <= 1'b1;
          end
        end
        ST_TRIGGERED: begin
          if (i_set_capture_done) begin
            r_state   <= ST_IDLE;
            r_trigger <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_trigger <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_trigger = r_trigger;
  assign o_busy    = r_busy;

`ifdef TRIGGER_UNIT_TRIG_COUNT_EN
  logic [TRIG_COUNT_W-1:0] r_trig_count;

  // Count each WAIT->TRIGGERED entry, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_count <= '0;
    end else if (w_fire && (r_trig_count != TRIG_COUNT_MAX)) begin
      r_trig_count <= r_trig_count + 1'b1;
    end
  end

  assign o_trig_count = r_trig_count;
`else
  assign o_trig_count = '0;
`endif

endmodule

// File: tb/tb_trigger_unit.sv
// tb_trigger_unit: self-checking bench for trigger_unit. A behavioural model
// (pin history queue + state rules) predicts trigger/busy/trig_count every
// cycle; directed scenarios add literal expectations, then random traffic runs.
module tb_trigger_unit;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 3;
  localparam int HOLDOFF_W   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_CH-1:0]    trigIn;
  logic [1:0]           trigSrc;
  logic [1:0]           trigMode;
  logic                 trigEn;
  logic                 armed;
  logic [HOLDOFF_W-1:0] holdoff;
  logic                 done;
  logic                 trigger;
  logic                 busy;
  logic [15:0]          trigCount;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Model state: 0 idle, 1 holdoff, 2 wait, 3 triggered
  int mState;
  int mCnt;
  int mCount;
  logic [NUM_CH-1:0] pinHist[$];

  trigger_unit #(
    .NUM_CH(NUM_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .HOLDOFF_W(HOLDOFF_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_trig_in(trigIn),
    .i_trig_src(trigSrc),
    .i_trig_mode(trigMode),
    .i_trig_en(trigEn),
    .i_armed(armed),
    .i_holdoff(holdoff),
    .i_set_capture_done(done),
    .o_trigger(trigger),
    .o_busy(busy),
    .o_trig_count(trigCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    pinHist.delete();
    for (int i = 0; i <= SYNC_STAGES; i++) pinHist.push_back('0);
    mState = 0;
    mCnt = 0;
    mCount = 0;
  endtask

  // pinHist holds pins sampled at the last SYNC_STAGES+1 edges (oldest first):
  // entry 1 is the synchronised level, entry 0 the value one cycle earlier.
  function automatic logic modelEvent();
    logic [NUM_CH-1:0] prevV;
    logic [NUM_CH-1:0] curV;
    int c;
    prevV = pinHist[0];
    curV = pinHist[1];
    c = int'(trigSrc);
    if (c >= NUM_CH) return 1'b0;
    case (trigMode)
      2'b00:   return !curV[c] && prevV[c];
      2'b01:   return curV[c] && !prevV[c];
      2'b10:   return curV[c] != prevV[c];
      default: return curV[c];
    endcase
  endfunction

  task automatic stepModel();
    logic ev;
    ev = modelEvent();
    case (mState)
      0: if (trigEn) begin mState = 1; mCnt = int'(holdoff); end
      1: begin
        if (!trigEn) mState = 0;
        else if (mCnt == 0) mState = 2;
        else mCnt--;
      end
      2: begin
        if (!trigEn) mState = 0;
        else if (!done && ev && armed) begin
          mState = 3;
          if (mCount < 65535) mCount++;
        end
      end
      default: if (done) mState = 0;
    endcase
    pinHist.push_back(trigIn);
    void'(pinHist.pop_front());
  endtask

  function automatic logic [15:0] expCount();
`ifdef TRIGGER_UNIT_TRIG_COUNT_EN
    return mCount[15:0];
`else
    return 16'd0;
`endif
  endfunction

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model trigger", {31'd0, trigger}, {31'd0, mState == 3});
      checkOutput("model busy", {31'd0, busy}, {31'd0, mState != 0});
      checkOutput("model trig_count", {16'd0, trigCount}, {16'd0, expCount()});
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!rst_n) resetModel();
    else stepModel();
    #1;
  endtask

  task automatic settle();
    trigIn = '0;
    done = 1'b0;
    trigEn = 1'b0;
    repeat (6) tick();
  endtask

  task automatic applyStimulus(input logic [1:0] src, input logic [1:0] mode,
                               input logic [15:0] hold, input logic arm);
    trigSrc = src;
    trigMode = mode;
    holdoff = hold;
    armed = arm;
    trigEn = 1'b1;
  endtask

  task automatic finishCapture();
    done = 1'b1;
    tick();
    done = 1'b0;
    trigEn = 1'b0;
  endtask

  initial begin
    int edges;
    rst_n = 1'b0;
    trigIn = '0;
    trigSrc = '0;
    trigMode = '0;
    trigEn = 1'b0;
    armed = 1'b0;
    holdoff = '0;
    done = 1'b0;
    resetModel();
    repeat (3) tick();
    rst_n = 1'b1;
    checkEn = 1'b1;
    checkOutput("reset trigger", {31'd0, trigger}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset trig_count", {16'd0, trigCount}, 32'd0);

    // Rising edge on channel 2 with zero holdoff
    applyStimulus(2'd2, 2'b01, 16'd0, 1'b1);
    tick();
    tick();
    checkOutput("wait busy", {31'd0, busy}, 32'd1);
    trigIn[2] = 1'b1;
    edges = 0;
    while (trigger !== 1'b1 && edges < 10) begin
      tick();
      edges++;
      if (edges == 3) trigIn[2] = 1'b0;
    end
    checkOutput("rise latency edges", edges, 32'd4);
    repeat (5) tick();
    checkOutput("sticky trigger", {31'd0, trigger}, 32'd1);
    finishCapture();
    checkOutput("done clears trigger", {31'd0, trigger}, 32'd0);
    checkOutput("done to idle busy", {31'd0, busy}, 32'd0);
    settle();

    // Holdoff of 10: edge at cycle 5 ignored, edge at cycle 20 triggers
    applyStimulus(2'd2, 2'b01, 16'd10, 1'b1);
    for (int i = 1; i <= 23; i++) begin
      trigIn[2] = ((i >= 5 && i <= 7) || (i >= 20 && i <= 22));
      tick();
      checkOutput("holdoff busy", {31'd0, busy}, 32'd1);
      if (i == 22) checkOutput("holdoff first ignored", {31'd0, trigger}, 32'd0);
      if (i == 23) checkOutput("holdoff second fires", {31'd0, trigger}, 32'd1);
    end
    finishCapture();
    settle();

    // armed gating
    applyStimulus(2'd2, 2'b01, 16'd0, 1'b0);
    tick();
    tick();
    trigIn[2] = 1'b1;
    repeat (6) tick();
    checkOutput("unarmed edge dropped", {31'd0, trigger}, 32'd0);
    armed = 1'b1;
    repeat (6) tick();
    checkOutput("armed while high", {31'd0, trigger}, 32'd0);
    trigIn[2] = 1'b0;
    repeat (4) tick();
    trigIn[2] = 1'b1;
    repeat (4) tick();
    checkOutput("next rise fires", {31'd0, trigger}, 32'd1);
    finishCapture();
    settle();

    // Source switch with static pins
    trigIn = 4'b0001;
    applyStimulus(2'd1, 2'b01, 16'd0, 1'b1);
    repeat (6) tick();
    trigSrc = 2'd0;
    repeat (3) tick();
    checkOutput("src switch no edge", {31'd0, trigger}, 32'd0);
    trigMode = 2'b11;
    tick();
    checkOutput("level after switch", {31'd0, trigger}, 32'd1);
    finishCapture();
    settle();

    // done beats a simultaneous event; aborts from WAIT and HOLDOFF
    applyStimulus(2'd2, 2'b01, 16'd0, 1'b1);
    tick();
    tick();
    trigIn[2] = 1'b1;
    repeat (3) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (4) tick();
    checkOutput("done beats event", {31'd0, trigger}, 32'd0);
    checkOutput("stay in wait", {31'd0, busy}, 32'd1);
    trigEn = 1'b0;
    tick();
    checkOutput("abort wait", {31'd0, busy}, 32'd0);
    holdoff = 16'd5;
    trigEn = 1'b1;
    tick();
    checkOutput("enter holdoff", {31'd0, busy}, 32'd1);
    trigEn = 1'b0;
    tick();
    checkOutput("abort holdoff", {31'd0, busy}, 32'd0);
    settle();

    // Asynchronous reset while triggered
    applyStimulus(2'd2, 2'b01, 16'd0, 1'b1);
    tick();
    tick();
    trigIn[2] = 1'b1;
    repeat (4) tick();
    checkOutput("pre-reset trigger", {31'd0, trigger}, 32'd1);
    #2;
    rst_n = 1'b0;
    resetModel();
    trigIn = '0;
    trigEn = 1'b0;
    #1;
    checkOutput("async reset trigger", {31'd0, trigger}, 32'd0);
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    settle();

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) trigIn[c] = ~trigIn[c];
      end
      if ($urandom_range(0, 31) == 0) trigSrc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) trigMode = 2'($urandom_range(0, 3));
      trigEn = ($urandom_range(0, 49) != 0);
      armed = ($urandom_range(0, 3) != 0);
      holdoff = 16'($urandom_range(0, 6));
      done = ($urandom_range(0, 11) == 0);
      tick();
    end
    settle();

    // Trigger count after a fresh reset and three full cycles
    rst_n = 1'b0;
    resetModel();
    #2;
    rst_n = 1'b1;
    checkOutput("count cleared", {16'd0, trigCount}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'd1, 2'b01, 16'd0, 1'b1);
      tick();
      tick();
      trigIn[1] = 1'b1;
      repeat (4) tick();
      checkOutput("count cycle trigger", {31'd0, trigger}, 32'd1);
      finishCapture();
      settle();
    end
`ifdef TRIGGER_UNIT_TRIG_COUNT_EN
    checkOutput("trig_count three", {16'd0, trigCount}, 32'd3);
`else
    checkOutput("trig_count tied", {16'd0, trigCount}, 32'd0);
`endif

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
